// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1 UART transmitter: pops one word per frame from a synchronous FIFO
// and shifts it out LSB first between a low start bit and a high stop bit.
//
//   state   | meaning
//   IDLE    | line high, waiting for tx_enable and a non-empty FIFO
//   POP     | one-cycle rd_en strobe to the FIFO
//   LOAD    | FIFO data_out now valid, capture into the shift register
//   START   | start bit (line low)
//   DATA    | data bits, LSB first
//   STOP    | stop bit (line high), frame_done on its last cycle
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  input  logic                  tx_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_POP   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  rd_en_q, rd_en_d;
  logic                  done_q, done_d;
  logic                  cnt_wrap;
  logic                  pop_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    rd_en_d  = 1'b0;
    done_d   = 1'b0;
    cnt_wrap = (cnt_q == CNT_LAST);
    pop_ok   = tx_enable && !fifo_empty;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (pop_ok) begin
          state_d = S_POP;
          rd_en_d = 1'b1;
        end
      end
      S_POP: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = fifo_data;
        tx_d    = 1'b0;
        cnt_d   = '0;
        state_d = S_START;
      end
      S_START: begin
        if (cnt_wrap) begin
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_wrap) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_wrap) begin
          // The FIFO is only looked at here and in IDLE.
          cnt_d = '0;
          if (pop_ok) begin
            state_d = S_POP;
            rd_en_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d  = cnt_q + 1'b1;
          done_d = (cnt_q == CNT_PRE);
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      done_q  <= done_d;
    end
  end

  assign tx         = tx_q;
  assign fifo_rd_en = rd_en_q;
  assign frame_done = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FIFO and a cycle-counting
// UART receiver running at CLKS_PER_BIT=4.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_rd_en;
  logic       tx_enable;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int total = 0;
  int bad   = 0;

  fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .tx_enable (tx_enable),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: registered data_out, written by the bench at negedges.
  logic [7:0] mem [0:63];
  int wr_cnt = 0;
  int rd_cnt = 0;
  assign fifo_empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    if (fifo_rd_en && (wr_cnt != rd_cnt)) begin
      fifo_data <= mem[rd_cnt % 64];
      rd_cnt    <= rd_cnt + 1;
    end
  end

  // Monitor and receiver, all sampled on the falling edge.
  int         pop_n = 0;
  int         bad_pop_n = 0;
  int         done_n = 0;
  int         rx_n = 0;
  int         rx_err = 0;
  logic       rx_busy = 1'b0;
  int         rx_cnt = 0;
  int         rx_t0 = 0;
  logic [9:0] rx_bits = '0;
  logic [7:0] rx_data [0:31];
  int         rx_t [0:31];
  int         rb;
  int         rpos;

  always @(negedge clk) begin
    if (frame_done === 1'b1) done_n <= done_n + 1;
    if (fifo_rd_en === 1'b1) pop_n <= pop_n + 1;
    if (fifo_rd_en === 1'b1 && fifo_empty) bad_pop_n <= bad_pop_n + 1;
    if (rst === 1'b1) begin
      rx_busy <= 1'b0;
    end else if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy <= 1'b1;
        rx_cnt  <= 1;
        rx_bits <= '0;
        rx_t0   <= cyc;
      end
    end else begin
      rb   = rx_cnt / CPB;
      rpos = rx_cnt % CPB;
      if (rpos == 0) rx_bits[rb] <= tx;
      else if (rpos == CPB - 1 && tx !== rx_bits[rb]) rx_err <= rx_err + 1;
      if (rx_cnt == FRAME - 1) begin
        if (rx_bits[9] !== 1'b1) rx_err <= rx_err + 1;
        rx_data[rx_n % 32] <= rx_bits[8:1];
        rx_t[rx_n % 32]    <= rx_t0;
        rx_n    <= rx_n + 1;
        rx_busy <= 1'b0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  task automatic push(input logic [7:0] v);
    mem[wr_cnt % 64] = v;
    wr_cnt = wr_cnt + 1;
  endtask

  task automatic wait_rx(input int target, input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (rx_n < target) begin
      @(negedge clk);
      n++;
      if (n > limit) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_tx_low(input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    while (tx !== 1'b0) begin
      @(negedge clk);
      n++;
      if (n > limit) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tx_enable = 1'b1;
    push(8'hA5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || fifo_rd_en !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_outputs cyc%0d: got tx=%b rd_en=%b busy=%b done=%b want 1 0 0 0",
                 i, tx, fifo_rd_en, busy, frame_done);
      end
    end
  endtask

  task automatic test_single_byte;
    logic [9:0] f;
    int p0, d0, r0;
    bit ok;
    f  = {1'b1, 8'hA5, 1'b0};
    p0 = pop_n;
    d0 = done_n;
    r0 = rx_n;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (fifo_rd_en !== 1'b1 || busy !== 1'b1 || tx !== 1'b1) begin
      bad++;
      $display("FAIL sb_pop: got rd_en=%b busy=%b tx=%b want 1 1 1", fifo_rd_en, busy, tx);
    end
    @(negedge clk);
    total++;
    if (fifo_rd_en !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL sb_load: got rd_en=%b tx=%b want 0 1", fifo_rd_en, tx);
    end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      total++;
      if (tx !== f[i / CPB] || frame_done !== (i == FRAME - 1)) begin
        bad++;
        $display("FAIL sb_line cyc%0d: got tx=%b done=%b want tx=%b done=%b",
                 i, tx, frame_done, f[i / CPB], (i == FRAME - 1));
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || tx !== 1'b1 || frame_done !== 1'b0) begin
      bad++;
      $display("FAIL sb_after: got busy=%b tx=%b done=%b want 0 1 0", busy, tx, frame_done);
    end
    wait_rx(r0 + 1, 10, ok);
    repeat (3) @(negedge clk);
    total++;
    if (!ok || rx_data[r0 % 32] !== 8'hA5) begin
      bad++;
      $display("FAIL sb_rx: got %h (ok=%0d) want a5", rx_data[r0 % 32], ok);
    end
    total++;
    if (pop_n - p0 != 1 || done_n - d0 != 1) begin
      bad++;
      $display("FAIL sb_counts: got pops=%0d dones=%0d want 1 1", pop_n - p0, done_n - d0);
    end
  endtask

  task automatic test_back_to_back;
    int p0, d0, r0;
    bit ok;
    logic [7:0] want;
    p0 = pop_n;
    d0 = done_n;
    r0 = rx_n;
    push(8'h01);
    push(8'h02);
    push(8'h03);
    wait_rx(r0 + 3, 3 * (FRAME + 2) + 30, ok);
    repeat (5) @(negedge clk);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL b2b_timeout: got %0d frames want 3", rx_n - r0);
    end
    for (int i = 0; i < 3; i++) begin
      want = 8'(i + 1);
      total++;
      if (rx_data[(r0 + i) % 32] !== want) begin
        bad++;
        $display("FAIL b2b_byte%0d: got %h want %h", i, rx_data[(r0 + i) % 32], want);
      end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (rx_t[(r0 + i + 1) % 32] - rx_t[(r0 + i) % 32] != FRAME + 2) begin
        bad++;
        $display("FAIL b2b_period%0d: got %0d want %0d", i,
                 rx_t[(r0 + i + 1) % 32] - rx_t[(r0 + i) % 32], FRAME + 2);
      end
    end
    total++;
    if (pop_n - p0 != 3 || done_n - d0 != 3) begin
      bad++;
      $display("FAIL b2b_counts: got pops=%0d dones=%0d want 3 3", pop_n - p0, done_n - d0);
    end
    total++;
    if (fifo_empty !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
      bad++;
      $display("FAIL b2b_end: got empty=%b busy=%b tx=%b want 1 0 1", fifo_empty, busy, tx);
    end
  endtask

  task automatic test_flow_gating;
    int p0, r0;
    bit ok;
    bit saw_low;
    tx_enable = 1'b0;
    p0 = pop_n;
    r0 = rx_n;
    push(8'h55);
    saw_low = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) saw_low = 1'b1;
    end
    total++;
    if (saw_low || pop_n - p0 != 0) begin
      bad++;
      $display("FAIL gate_hold: got line_active=%0d pops=%0d want 0 0", saw_low, pop_n - p0);
    end
    tx_enable = 1'b1;
    wait_tx_low(10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL gate_start: got tx=%b want start bit 0", tx);
    end
    repeat (12) @(negedge clk);
    push(8'h66);
    tx_enable = 1'b0;
    wait_rx(r0 + 1, FRAME + 10, ok);
    total++;
    if (!ok || rx_data[r0 % 32] !== 8'h55) begin
      bad++;
      $display("FAIL gate_byte: got %h (ok=%0d) want 55", rx_data[r0 % 32], ok);
    end
    repeat (50) @(negedge clk);
    total++;
    if (pop_n - p0 != 1 || fifo_empty !== 1'b0 || busy !== 1'b0 || tx !== 1'b1 || rx_n != r0 + 1) begin
      bad++;
      $display("FAIL gate_stop: got pops=%0d empty=%b busy=%b tx=%b frames=%0d want 1 0 0 1 1",
               pop_n - p0, fifo_empty, busy, tx, rx_n - r0);
    end
  endtask

  task automatic test_reset_mid_frame;
    int p0, r0;
    bit ok;
    p0 = pop_n;
    r0 = rx_n;
    push(8'h3C);
    tx_enable = 1'b1;
    wait_tx_low(10, ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL rmf_start: got tx=%b want start bit 0", tx);
    end
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      bad++;
      $display("FAIL rmf_reset: got tx=%b busy=%b rd_en=%b want 1 0 0", tx, busy, fifo_rd_en);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_rx(r0 + 1, FRAME + 20, ok);
    repeat (5) @(negedge clk);
    total++;
    if (!ok || rx_data[r0 % 32] !== 8'h3C || rx_n != r0 + 1) begin
      bad++;
      $display("FAIL rmf_next: got %h frames=%0d (ok=%0d) want 3c 1", rx_data[r0 % 32], rx_n - r0, ok);
    end
    total++;
    if (pop_n - p0 != 2 || busy !== 1'b0 || fifo_empty !== 1'b1) begin
      bad++;
      $display("FAIL rmf_counts: got pops=%0d busy=%b empty=%b want 2 0 1", pop_n - p0, busy, fifo_empty);
    end
  endtask

  task automatic test_empty_protect;
    int p0, d0, r0;
    bit ok;
    p0 = pop_n;
    d0 = done_n;
    r0 = rx_n;
    push(8'hC3);
    wait_rx(r0 + 1, FRAME + 10, ok);
    repeat (10) @(negedge clk);
    total++;
    if (!ok || rx_data[r0 % 32] !== 8'hC3) begin
      bad++;
      $display("FAIL ep_byte: got %h (ok=%0d) want c3", rx_data[r0 % 32], ok);
    end
    total++;
    if (pop_n - p0 != 1 || done_n - d0 != 1 || bad_pop_n != 0) begin
      bad++;
      $display("FAIL ep_pops: got pops=%0d dones=%0d empty_pops=%0d want 1 1 0",
               pop_n - p0, done_n - d0, bad_pop_n);
    end
    total++;
    if (fifo_empty !== 1'b1 || busy !== 1'b0 || tx !== 1'b1 || rx_err != 0) begin
      bad++;
      $display("FAIL ep_end: got empty=%b busy=%b tx=%b line_errors=%0d want 1 0 1 0",
               fifo_empty, busy, tx, rx_err);
    end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_flow_gating;
    test_reset_mid_frame;
    test_empty_protect;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
